// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned PC_W   = 64;
  localparam int unsigned INST_W = 32;

  localparam logic [PC_W-1:0]   IFU_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [INST_W-1:0] IFU_NOP_INST = 32'h0000_0013;

  // Fault code presented to decode alongside each instruction
  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_ACCESS   = 2'b10
  } fault_e;

  // Fetch FSM states
  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } ifu_state_e;

  // A fetch target must be word aligned to be sent to instruction memory
  function automatic logic pc_misaligned(input logic [PC_W-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, keeps a single request outstanding
// to instruction memory and hands each fetched word to decode. Redirects
// from execute always win; any response that belongs to the old path is
// drained and dropped before fetching at the new target.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [PC_W-1:0]   RESET_PC = IFU_RESET_PC,
  parameter logic [INST_W-1:0] NOP_INST = IFU_NOP_INST
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_valid_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  output logic              imem_req_valid_o,
  output logic [PC_W-1:0]   imem_req_addr_o,
  input  logic              imem_req_ready_i,
  input  logic              imem_resp_valid_i,
  input  logic [INST_W-1:0] imem_resp_data_i,
  input  logic              imem_resp_err_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [1:0]        fault_o
);

  ifu_state_e        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  fault_e            fault_q, fault_d;
  logic              pend_valid_q, pend_valid_d;
  logic [PC_W-1:0]   pend_pc_q, pend_pc_d;

  logic              req_fire;
  logic              inst_fire;
  logic [PC_W-1:0]   pc_inc;
  logic              resolve;
  logic [PC_W-1:0]   resolve_pc;

  // pc_q is both the address being fetched and the PC of the held instruction
  assign imem_req_valid_o = (state_q == ST_REQ);
  assign imem_req_addr_o  = pc_q;
  assign inst_valid_o     = (state_q == ST_HOLD) && !redirect_valid_i;
  assign inst_o           = inst_q;
  assign pc_o             = pc_q;
  assign fault_o          = fault_q;

  assign req_fire  = imem_req_valid_o && imem_req_ready_i;
  assign inst_fire = inst_valid_o && inst_ready_i;
  assign pc_inc    = pc_q + 64'd4;

  // Next-state logic; "resolve" means the memory side is quiet and we pick
  // the next fetch point, faulting locally instead of fetching if misaligned
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    fault_d      = fault_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    resolve      = 1'b0;
    resolve_pc   = pc_q;

    unique case (state_q)
      ST_RST: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        if (req_fire) begin
          pend_valid_d = 1'b0;
          if (redirect_valid_i) begin
            pc_d    = redirect_pc_i;
            state_d = ST_DRAIN;
          end else if (pend_valid_q) begin
            pc_d    = pend_pc_q;
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (redirect_valid_i) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = redirect_pc_i;
        end
      end

      ST_WAIT: begin
        if (redirect_valid_i) begin
          pc_d = redirect_pc_i;
          if (imem_resp_valid_i) begin
            resolve    = 1'b1;
            resolve_pc = redirect_pc_i;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (imem_resp_valid_i) begin
          state_d = ST_HOLD;
          if (imem_resp_err_i) begin
            inst_d  = NOP_INST;
            fault_d = FAULT_ACCESS;
          end else begin
            inst_d  = imem_resp_data_i;
            fault_d = FAULT_NONE;
          end
        end
      end

      ST_HOLD: begin
        if (redirect_valid_i) begin
          resolve    = 1'b1;
          resolve_pc = redirect_pc_i;
        end else if (inst_fire) begin
          resolve    = 1'b1;
          resolve_pc = pc_inc;
        end
      end

      ST_DRAIN: begin
        if (redirect_valid_i) begin
          pc_d = redirect_pc_i;
        end
        if (imem_resp_valid_i) begin
          resolve    = 1'b1;
          resolve_pc = redirect_valid_i ? redirect_pc_i : pc_q;
        end
      end

      default: begin
        state_d = ST_RST;
      end
    endcase

    if (resolve) begin
      pc_d   = resolve_pc;
      inst_d = NOP_INST;
      if (pc_misaligned(resolve_pc)) begin
        state_d = ST_HOLD;
        fault_d = FAULT_MISALIGN;
      end else begin
        state_d = ST_REQ;
        fault_d = FAULT_NONE;
      end
    end
  end

  // State, PC, output and pending-redirect registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_RST;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      fault_q      <= FAULT_NONE;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      fault_q      <= fault_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  // Memory must only respond while a request is outstanding
  a_resp_expected: assert property (@(posedge clk_i) disable iff (rst_i)
    imem_resp_valid_i |-> (state_q == ST_WAIT || state_q == ST_DRAIN));

  // A request is never withdrawn or moved before it is accepted
  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (imem_req_valid_o && !imem_req_ready_i) |=>
      (imem_req_valid_o && $stable(imem_req_addr_o)));

  // Only one request in flight: acceptance always drops the request line
  a_single_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    req_fire |=> !imem_req_valid_o);

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for the instruction fetch unit. The bench plays the
// instruction memory and decode; expected instructions are queued by each
// scenario and matched against every decode handshake.
module tb_ifu;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [1:0]  fault;
  } exp_t;

  logic        clk_i;
  logic        rst_i;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic [63:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        imem_resp_err_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic [1:0]  fault_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus plan applied at the next cycle
  logic        plan_redirect    = 1'b0;
  logic [63:0] plan_redirect_pc = '0;
  logic        plan_ready       = 1'b0;
  logic        plan_mem_ready   = 1'b1;
  logic        plan_err         = 1'b0;
  int          mem_latency      = 1;

  // Memory model and monitor state
  int          resp_wait = 0;
  logic [63:0] resp_addr = '0;
  int          cyc       = 0;
  int          req_cycles = 0;
  int          hs_count  = 0;
  logic [63:0] req_log[$];
  int          hs_cycles[$];
  exp_t        sb[$];

  ifu dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_pc_i     (redirect_pc_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .imem_resp_err_i   (imem_resp_err_i),
    .inst_valid_o      (inst_valid_o),
    .inst_ready_i      (inst_ready_i),
    .inst_o            (inst_o),
    .pc_o              (pc_o),
    .fault_o           (fault_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Instruction memory contents
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h8000_0000) return 32'h0010_0093;
    else if (a == 64'h8000_0004) return 32'h0020_0113;
    else return a[31:0] ^ 32'h5A5A_0003;
  endfunction

  task automatic exp_push(input logic [63:0] pc, input logic [31:0] inst, input logic [1:0] fault);
    exp_t e;
    e.pc    = pc;
    e.inst  = inst;
    e.fault = fault;
    sb.push_back(e);
  endtask

  // One clock: drive inputs after the falling edge, sample just after
  task automatic cycle();
    exp_t e;
    @(negedge clk_i);
    redirect_valid_i  = plan_redirect;
    redirect_pc_i     = plan_redirect_pc;
    plan_redirect     = 1'b0;
    inst_ready_i      = plan_ready;
    imem_req_ready_i  = plan_mem_ready;
    imem_resp_valid_i = 1'b0;
    imem_resp_data_i  = '0;
    imem_resp_err_i   = 1'b0;
    if (resp_wait > 0) begin
      resp_wait--;
      if (resp_wait == 0) begin
        imem_resp_valid_i = 1'b1;
        imem_resp_err_i   = plan_err;
        imem_resp_data_i  = plan_err ? 32'hDEAD_BEEF : mem_word(resp_addr);
        plan_err          = 1'b0;
      end
    end
    #1;
    if (imem_req_valid_o) req_cycles++;
    if (imem_req_valid_o && imem_req_ready_i) begin
      req_log.push_back(imem_req_addr_o);
      resp_addr = imem_req_addr_o;
      resp_wait = mem_latency;
    end
    if (inst_valid_o && inst_ready_i) begin
      hs_count++;
      hs_cycles.push_back(cyc);
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL scoreboard_unexpected: got pc=%h inst=%h fault=%b, required no instruction",
                 pc_o, inst_o, fault_o);
      end else begin
        e = sb.pop_front();
        if (pc_o !== e.pc || inst_o !== e.inst || fault_o !== e.fault) begin
          n_fail++;
          $display("[TB] FAIL scoreboard: got pc=%h inst=%h fault=%b, required pc=%h inst=%h fault=%b",
                   pc_o, inst_o, fault_o, e.pc, e.inst, e.fault);
        end
      end
    end
    cyc++;
  endtask

  task automatic apply_reset();
    rst_i          = 1'b1;
    plan_ready     = 1'b0;
    plan_mem_ready = 1'b1;
    plan_redirect  = 1'b0;
    plan_err       = 1'b0;
    mem_latency    = 1;
    resp_wait      = 0;
    cycle();
    cycle();
    rst_i = 1'b0;
    req_log.delete();
    hs_cycles.delete();
    sb.delete();
    hs_count = 0;
  endtask

  task automatic wait_handshakes(input int n, input int budget, input string name);
    int target;
    int k;
    target = hs_count + n;
    k = 0;
    while (hs_count < target && k < budget) begin
      cycle();
      k++;
    end
    n_checks++;
    if (hs_count < target) begin
      n_fail++;
      $display("[TB] FAIL %s_timeout: got %0d handshakes, required %0d", name, hs_count, target);
    end
  endtask

  task automatic wait_accept(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (req_log.size() < n && k < budget) begin
      cycle();
      k++;
    end
    n_checks++;
    if (req_log.size() < n) begin
      n_fail++;
      $display("[TB] FAIL %s_accept_timeout: got %0d requests, required %0d", name, req_log.size(), n);
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!inst_valid_o && k < budget);
    n_checks++;
    if (!inst_valid_o) begin
      n_fail++;
      $display("[TB] FAIL %s_valid_timeout: got inst_valid=0, required 1", name);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    plan_ready = 1'b0;
    plan_mem_ready = 1'b1;
    resp_wait = 0;
    cycle();
    n_checks++;
    if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_valids: got req=%b inst=%b, required 0 0", imem_req_valid_o, inst_valid_o);
    end
    n_checks++;
    if (inst_o !== NOP || pc_o !== RST_PC || fault_o !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got inst=%h pc=%h fault=%b, required %h %h 00", inst_o, pc_o, fault_o, NOP, RST_PC);
    end
    rst_i = 1'b0;
    req_log.delete();
    wait_accept(1, 4, "reset_first");
    n_checks++;
    if (req_log.size() < 1 || req_log[0] !== RST_PC) begin
      n_fail++;
      $display("[TB] FAIL reset_first_addr: got %h, required %h", imem_req_addr_o, RST_PC);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    plan_ready = 1'b1;
    exp_push(RST_PC, 32'h0010_0093, 2'b00);
    exp_push(64'h8000_0004, 32'h0020_0113, 2'b00);
    wait_handshakes(2, 30, "basic");
    n_checks++;
    if (hs_cycles.size() < 2 || hs_cycles[1] - hs_cycles[0] != 3) begin
      n_fail++;
      $display("[TB] FAIL basic_throughput: got %0d handshakes spacing %0d, required spacing 3",
               hs_cycles.size(), (hs_cycles.size() < 2) ? -1 : hs_cycles[1] - hs_cycles[0]);
    end
    n_checks++;
    if (req_log.size() < 2 || req_log[1] !== 64'h8000_0004) begin
      n_fail++;
      $display("[TB] FAIL basic_second_addr: got %0d requests, required second addr 80000004", req_log.size());
    end
  endtask

  task automatic test_stall();
    int n0;
    apply_reset();
    plan_ready = 1'b0;
    exp_push(RST_PC, 32'h0010_0093, 2'b00);
    wait_valid(10, "stall");
    n0 = req_cycles;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if (inst_valid_o !== 1'b1 || inst_o !== 32'h0010_0093 || pc_o !== RST_PC) begin
        n_fail++;
        $display("[TB] FAIL stall_stable: got valid=%b inst=%h pc=%h, required 1 00100093 %h",
                 inst_valid_o, inst_o, pc_o, RST_PC);
      end
    end
    n_checks++;
    if (req_cycles != n0) begin
      n_fail++;
      $display("[TB] FAIL stall_no_req: got %0d request cycles, required 0", req_cycles - n0);
    end
    plan_ready = 1'b1;
    wait_handshakes(1, 4, "stall_release");
    wait_accept(2, 4, "stall_next");
    n_checks++;
    if (req_log.size() < 2 || req_log[1] !== 64'h8000_0004) begin
      n_fail++;
      $display("[TB] FAIL stall_next_addr: got %h, required 80000004", imem_req_addr_o);
    end
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    plan_ready = 1'b1;
    exp_push(64'h8000_0100, mem_word(64'h8000_0100), 2'b00);
    wait_accept(1, 5, "rwait");
    plan_redirect = 1'b1;
    plan_redirect_pc = 64'h8000_0100;
    cycle();
    wait_handshakes(1, 10, "rwait");
    n_checks++;
    if (req_log.size() < 2 || req_log[1] !== 64'h8000_0100) begin
      n_fail++;
      $display("[TB] FAIL rwait_target_addr: got %0d requests, required second addr 80000100", req_log.size());
    end
    // Slow memory: the redirect lands while the response is still outstanding
    apply_reset();
    mem_latency = 2;
    plan_ready = 1'b1;
    exp_push(64'h8000_0200, mem_word(64'h8000_0200), 2'b00);
    wait_accept(1, 5, "rdrain");
    plan_redirect = 1'b1;
    plan_redirect_pc = 64'h8000_0200;
    cycle();
    cycle();
    n_checks++;
    if (imem_req_valid_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rdrain_no_req: got req_valid=%b, required 0", imem_req_valid_o);
    end
    wait_handshakes(1, 12, "rdrain");
    n_checks++;
    if (req_log.size() < 2 || req_log[1] !== 64'h8000_0200) begin
      n_fail++;
      $display("[TB] FAIL rdrain_target_addr: got %0d requests, required second addr 80000200", req_log.size());
    end
  endtask

  task automatic test_redirect_hold();
    int h0;
    apply_reset();
    plan_ready = 1'b0;
    exp_push(64'h8000_0300, mem_word(64'h8000_0300), 2'b00);
    wait_valid(10, "rhold");
    plan_ready = 1'b1;
    plan_redirect = 1'b1;
    plan_redirect_pc = 64'h8000_0300;
    h0 = hs_count;
    cycle();
    n_checks++;
    if (inst_valid_o !== 1'b0 || hs_count != h0) begin
      n_fail++;
      $display("[TB] FAIL rhold_kill: got valid=%b handshakes=%0d, required 0 and %0d", inst_valid_o, hs_count, h0);
    end
    wait_handshakes(1, 10, "rhold");
    n_checks++;
    if (req_log.size() < 2 || req_log[1] !== 64'h8000_0300) begin
      n_fail++;
      $display("[TB] FAIL rhold_target_addr: got %0d requests, required second addr 80000300", req_log.size());
    end
  endtask

  task automatic test_redirect_req();
    apply_reset();
    plan_ready = 1'b1;
    plan_mem_ready = 1'b0;
    exp_push(64'h8000_0400, mem_word(64'h8000_0400), 2'b00);
    cycle();
    plan_redirect = 1'b1;
    plan_redirect_pc = 64'h8000_0400;
    cycle();
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++;
      if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== RST_PC) begin
        n_fail++;
        $display("[TB] FAIL rreq_stable: got req=%b addr=%h, required 1 %h", imem_req_valid_o, imem_req_addr_o, RST_PC);
      end
    end
    plan_mem_ready = 1'b1;
    wait_accept(1, 3, "rreq");
    wait_handshakes(1, 12, "rreq");
    n_checks++;
    if (req_log.size() < 2 || req_log[0] !== RST_PC || req_log[1] !== 64'h8000_0400) begin
      n_fail++;
      $display("[TB] FAIL rreq_addrs: got %0d requests, required 80000000 then 80000400", req_log.size());
    end
  endtask

  task automatic test_misaligned();
    int n0;
    apply_reset();
    plan_ready = 1'b1;
    exp_push(64'h8000_0102, NOP, 2'b01);
    wait_accept(1, 5, "misal");
    plan_ready = 1'b0;
    plan_redirect = 1'b1;
    plan_redirect_pc = 64'h8000_0102;
    n0 = req_cycles;
    cycle();
    cycle();
    n_checks++;
    if (inst_valid_o !== 1'b1 || fault_o !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL misal_fault: got valid=%b fault=%b, required 1 01", inst_valid_o, fault_o);
    end
    n_checks++;
    if (pc_o !== 64'h8000_0102 || inst_o !== NOP) begin
      n_fail++;
      $display("[TB] FAIL misal_outputs: got pc=%h inst=%h, required 80000102 %h", pc_o, inst_o, NOP);
    end
    cycle();
    cycle();
    n_checks++;
    if (req_cycles != n0) begin
      n_fail++;
      $display("[TB] FAIL misal_no_req: got %0d request cycles, required 0", req_cycles - n0);
    end
    plan_ready = 1'b1;
    wait_handshakes(1, 3, "misal");
    plan_ready = 1'b0;
  endtask

  task automatic test_access_fault();
    apply_reset();
    plan_ready = 1'b1;
    plan_err = 1'b1;
    exp_push(RST_PC, NOP, 2'b10);
    exp_push(64'h8000_0004, 32'h0020_0113, 2'b00);
    wait_handshakes(1, 10, "access_fault");
    wait_handshakes(1, 10, "fault_clear");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    plan_ready = 1'b1;
    mem_latency = 2;
    wait_accept(1, 5, "rstmid");
    cycle();
    rst_i = 1'b1;
    resp_wait = 0;
    cycle();
    n_checks++;
    if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_o !== NOP || pc_o !== RST_PC || fault_o !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL rstmid_outputs: got req=%b valid=%b inst=%h pc=%h fault=%b, required reset values",
               imem_req_valid_o, inst_valid_o, inst_o, pc_o, fault_o);
    end
    rst_i = 1'b0;
    mem_latency = 1;
    req_log.delete();
    wait_accept(1, 4, "rstmid_restart");
    n_checks++;
    if (req_log.size() < 1 || req_log[0] !== RST_PC) begin
      n_fail++;
      $display("[TB] FAIL rstmid_first_addr: got %h, required %h", imem_req_addr_o, RST_PC);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    plan_ready = 1'b1;
    exp_push(64'hFFFF_FFFF_FFFF_FFFC, mem_word(64'hFFFF_FFFF_FFFF_FFFC), 2'b00);
    exp_push(64'h0, mem_word(64'h0), 2'b00);
    wait_accept(1, 5, "wrap");
    plan_redirect = 1'b1;
    plan_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    wait_handshakes(2, 20, "wrap");
    n_checks++;
    if (req_log.size() < 3 || req_log[1] !== 64'hFFFF_FFFF_FFFF_FFFC || req_log[2] !== 64'h0) begin
      n_fail++;
      $display("[TB] FAIL wrap_addrs: got %0d requests, required FFFFFFFFFFFFFFFC then 0", req_log.size());
    end
  endtask

  // Runaway guard
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i             = 1'b1;
    redirect_valid_i  = 1'b0;
    redirect_pc_i     = '0;
    imem_req_ready_i  = 1'b0;
    imem_resp_valid_i = 1'b0;
    imem_resp_data_i  = '0;
    imem_resp_err_i   = 1'b0;
    inst_ready_i      = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_req();
    test_misaligned();
    test_access_fault();
    test_reset_mid();
    test_wrap();
    apply_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
